// File: rtl/tpmem_pkg.sv
// Shared types and index helpers for the ping-pong truncating transpose memory.
package tpmem_pkg;

  typedef enum logic {
    MODE_TRANSPOSE = 1'b0,
    MODE_PASS      = 1'b1
  } mode_e;

  localparam int unsigned DEF_N     = 16;
  localparam int unsigned DEF_CNT_W = $clog2(DEF_N);

  // Counter width for an N-entry row/column index.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Number of words physically stored for row r.
  function automatic int unsigned row_kept_words(input int unsigned r, input int unsigned n,
                                                 input int unsigned full_rows,
                                                 input int unsigned keep_w);
    return (r < full_rows) ? n : keep_w;
  endfunction

  // LSB position of word idx in an MSB-first packed vector.
  function automatic int unsigned word_lsb(input int unsigned idx, input int unsigned n,
                                           input int unsigned bw);
    return (n - 1 - idx) * bw;
  endfunction

endpackage

// File: rtl/tpmem_bank.sv
// One bank of the transpose memory: N rows with truncated tails, a row write port
// and a combinational column/row read mux with zero-fill of dropped words.
module tpmem_bank
  import tpmem_pkg::*;
#(
  parameter int unsigned BW        = 12,
  parameter int unsigned N         = 16,
  parameter int unsigned FULL_ROWS = 12,
  parameter int unsigned KEEP_W    = 12,
  localparam int unsigned CNT_W    = cnt_width(N)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [CNT_W-1:0]  wr_row,
  input  logic [N*BW-1:0]   wr_data,
  input  logic [CNT_W-1:0]  rd_idx,
  input  mode_e             rd_mode,
  output logic [N*BW-1:0]   rd_data
);

  logic [N*BW-1:0] rows [N];

  for (genvar r = 0; r < N; r++) begin : g_row
    localparam int unsigned KW = row_kept_words(r, N, FULL_ROWS, KEEP_W);
    logic [KW*BW-1:0] row_q, row_d;

    // Capture only the kept leading words of the incoming row.
    always_comb begin
      row_d = row_q;
      if (we && (wr_row == CNT_W'(r))) row_d = wr_data[N*BW-1 -: KW*BW];
    end

    // Row storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
      row_q <= row_d;
    end

    if (KW == N) begin : g_full
      assign rows[r] = row_q;
    end else begin : g_trunc
      assign rows[r] = {row_q, {((N - KW) * BW){1'b0}}};
    end
  end

  // Select column rd_idx (transpose) or row rd_idx (pass-through).
  always_comb begin
    rd_data = '0;
    for (int unsigned r = 0; r < N; r++) begin
      if (rd_mode == MODE_PASS)
        rd_data[word_lsb(r, N, BW) +: BW] = rows[rd_idx][word_lsb(r, N, BW) +: BW];
      else
        rd_data[word_lsb(r, N, BW) +: BW] = rows[r][word_lsb(32'(rd_idx), N, BW) +: BW];
    end
  end

endmodule

// File: rtl/tpmem_pp_trunc.sv
// Double-buffered truncating transpose memory: rows in, columns out, with
// per-block pass-through mode and an end-of-block marker.
module tpmem_pp_trunc
  import tpmem_pkg::*;
#(
  parameter int unsigned BW        = 12,
  parameter int unsigned N         = 16,
  parameter int unsigned FULL_ROWS = 12,
  parameter int unsigned KEEP_W    = 12
) (
  input  logic            i_clk,
  input  logic            i_Reset,
  input  logic [N*BW-1:0] i_data,
  input  logic            i_enable,
  input  logic            i_mode,
  output logic [N*BW-1:0] o_data,
  output logic            o_en,
  output logic            o_last,
  output logic            o_bank
);

  localparam int unsigned      CNT_W    = cnt_width(N);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic             wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [1:0]       full_q, full_d;
  mode_e            bank_mode_q [2];
  mode_e            bank_mode_d [2];
  logic [N*BW-1:0]  o_data_q, o_data_d;
  logic             o_en_q, o_en_d, o_last_q, o_last_d, o_bank_q, o_bank_d;
  logic [N*BW-1:0]  rd_vec [2];
  logic             rd_active;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    tpmem_bank #(
      .BW        (BW),
      .N         (N),
      .FULL_ROWS (FULL_ROWS),
      .KEEP_W    (KEEP_W)
    ) u_bank (
      .clk     (i_clk),
      .we      (i_enable && (wr_bank_q == 1'(b))),
      .wr_row  (wr_cnt_q),
      .wr_data (i_data),
      .rd_idx  (rd_cnt_q),
      .rd_mode (bank_mode_q[b]),
      .rd_data (rd_vec[b])
    );
  end

  // Banks are filled and drained in the same alternating order, so the drain
  // side only has to wait for its own current bank to become full.
  assign rd_active = full_q[rd_bank_q];

  // Next-state for write/read counters, full flags and output registers.
  always_comb begin
    wr_cnt_d    = wr_cnt_q;
    wr_bank_d   = wr_bank_q;
    rd_cnt_d    = rd_cnt_q;
    rd_bank_d   = rd_bank_q;
    full_d      = full_q;
    bank_mode_d = bank_mode_q;
    o_data_d    = '0;
    o_en_d      = 1'b0;
    o_last_d    = 1'b0;
    o_bank_d    = 1'b0;

    if (rd_active) begin
      o_data_d = rd_vec[rd_bank_q];
      o_en_d   = 1'b1;
      o_last_d = (rd_cnt_q == LAST_IDX);
      o_bank_d = rd_bank_q;
      rd_cnt_d = rd_cnt_q + 1'b1;
      if (rd_cnt_q == LAST_IDX) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
      end
    end

    if (i_enable) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
      if (wr_cnt_q == '0) bank_mode_d[wr_bank_q] = mode_e'(i_mode);
      if (wr_cnt_q == LAST_IDX) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_Reset) begin
      wr_cnt_q       <= '0;
      wr_bank_q      <= 1'b0;
      rd_cnt_q       <= '0;
      rd_bank_q      <= 1'b0;
      full_q         <= '0;
      bank_mode_q[0] <= MODE_TRANSPOSE;
      bank_mode_q[1] <= MODE_TRANSPOSE;
      o_data_q       <= '0;
      o_en_q         <= 1'b0;
      o_last_q       <= 1'b0;
      o_bank_q       <= 1'b0;
    end else begin
      wr_cnt_q    <= wr_cnt_d;
      wr_bank_q   <= wr_bank_d;
      rd_cnt_q    <= rd_cnt_d;
      rd_bank_q   <= rd_bank_d;
      full_q      <= full_d;
      bank_mode_q <= bank_mode_d;
      o_data_q    <= o_data_d;
      o_en_q      <= o_en_d;
      o_last_q    <= o_last_d;
      o_bank_q    <= o_bank_d;
    end
  end

  assign o_data = o_data_q;
  assign o_en   = o_en_q;
  assign o_last = o_last_q;
  assign o_bank = o_bank_q;

  // A completed block must never be overwritten before it has drained.
  a_no_write_full: assert property (@(posedge i_clk) disable iff (i_Reset)
                                    !(i_enable && full_q[wr_bank_q]));

endmodule

// File: tb/tb_tpmem_pp_trunc.sv
// Scoreboard bench for tpmem_pp_trunc (default parameters plus a small N=8 instance).
module tb_tpmem_pp_trunc;

  localparam int BW = 12;
  localparam int N  = 16;
  localparam int FR = 12;
  localparam int KW = 12;
  localparam int VW = N * BW;

  localparam int N8  = 8;
  localparam int FR8 = 6;
  localparam int KW8 = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          mode = 1'b0;
  logic [VW-1:0] din = '0;
  logic [VW-1:0] o_data;
  logic          o_en, o_last, o_bank;

  logic            en8 = 1'b0;
  logic            mode8 = 1'b0;
  logic [N8*BW-1:0] din8 = '0;
  logic [N8*BW-1:0] dout8;
  logic            oen8, olast8, obank8;

  always #5 clk = ~clk;

  tpmem_pp_trunc #(.BW(BW), .N(N), .FULL_ROWS(FR), .KEEP_W(KW)) dut (
    .i_clk(clk), .i_Reset(rst), .i_data(din), .i_enable(en), .i_mode(mode),
    .o_data(o_data), .o_en(o_en), .o_last(o_last), .o_bank(o_bank)
  );

  tpmem_pp_trunc #(.BW(BW), .N(N8), .FULL_ROWS(FR8), .KEEP_W(KW8)) dut8 (
    .i_clk(clk), .i_Reset(rst), .i_data(din8), .i_enable(en8), .i_mode(mode8),
    .o_data(dout8), .o_en(oen8), .o_last(olast8), .o_bank(obank8)
  );

  typedef struct {
    logic [VW-1:0] data;
    logic          last;
    logic          bank;
    int unsigned   cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  logic        exp_bank = 1'b0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Monitor: pop and compare every valid vector; idle cycles must be zero.
  always @(negedge clk) begin
    exp_t e;
    if (o_en) begin
      if (sb.size() == 0) begin
        check("unexpected_en", VW'(o_en), '0);
      end else begin
        e = sb.pop_front();
        check("data", o_data, e.data);
        check("last", VW'(o_last), VW'(e.last));
        check("bank", VW'(o_bank), VW'(e.bank));
        check("cycle", VW'(cyc), VW'(e.cyc));
      end
    end else begin
      check("idle_data", o_data, '0);
      check("idle_last", VW'(o_last), '0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    sb.delete();
    exp_bank = 1'b0;
    check("rst_en", VW'(o_en), '0);
    check("rst_data", o_data, '0);
    check("rst_last", VW'(o_last), '0);
    check("rst_bank", VW'(o_bank), '0);
  endtask

  // Drive rows_to_send rows of a block; a complete block pushes its N expected vectors.
  task automatic send_block(input logic m, input int gap_max, input bit toggle,
                            input int rows_to_send, input bit pattern);
    logic [BW-1:0] w [N][N];
    exp_t          e;
    int            rr, cc;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        w[r][c] = pattern ? BW'(r * 16 + c) : BW'($urandom);
    for (int r = 0; r < rows_to_send; r++) begin
      if (gap_max > 0) begin
        en = 1'b0;
        repeat ($urandom_range(0, gap_max)) tick();
      end
      for (int c = 0; c < N; c++) din[(N-1-c)*BW +: BW] = w[r][c];
      en   = 1'b1;
      mode = (toggle && (r % 2 == 1)) ? ~m : m;
      if (r == N - 1) begin
        for (int c = 0; c < N; c++) begin
          e.data = '0;
          for (int r2 = 0; r2 < N; r2++) begin
            rr = m ? c : r2;
            cc = m ? r2 : c;
            e.data[(N-1-r2)*BW +: BW] = (rr >= FR && cc >= KW) ? '0 : w[rr][cc];
          end
          e.last = (c == N - 1);
          e.bank = exp_bank;
          e.cyc  = cyc + 2 + c;
          sb.push_back(e);
        end
        exp_bank = ~exp_bank;
      end
      tick();
    end
    en = 1'b0;
  endtask

  task automatic drain();
    repeat (N + 4) tick();
  endtask

  logic [N8*BW-1:0] exp8;

  initial begin
    do_reset();

    // Single pattern block, transpose mode.
    send_block(1'b0, 0, 1'b0, N, 1'b1);
    drain();

    // Three blocks back-to-back, modes 0,1,0; banks 0,1,0, continuous output.
    do_reset();
    send_block(1'b0, 0, 1'b0, N, 1'b1);
    send_block(1'b1, 0, 1'b0, N, 1'b1);
    send_block(1'b0, 0, 1'b0, N, 1'b1);
    drain();
    drain();
    drain();

    // Random enable gaps inside a block.
    send_block(1'b0, 2, 1'b0, N, 1'b1);
    drain();

    // Mode toggled on rows 1..15; row 0 value governs.
    send_block(1'b1, 0, 1'b1, N, 1'b1);
    send_block(1'b0, 0, 1'b1, N, 1'b0);
    drain();
    drain();

    // Random data, pass-through, with gaps.
    send_block(1'b1, 1, 1'b0, N, 1'b0);
    drain();

    // Reset mid-stream: partial block 2 in flight, block 1 draining.
    do_reset();
    send_block(1'b0, 0, 1'b0, N, 1'b1);
    send_block(1'b1, 0, 1'b0, 8, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    exp_bank = 1'b0;
    check("midrst_en", VW'(o_en), '0);
    check("midrst_data", o_data, '0);
    send_block(1'b0, 0, 1'b0, N, 1'b0);
    drain();

    // Small instance: N=8, FULL_ROWS=6, KEEP_W=4, all-ones rows.
    din8 = '1;
    for (int r = 0; r < N8; r++) begin
      en8 = 1'b1;
      tick();
    end
    en8 = 1'b0;
    tick();
    for (int c = 0; c < N8; c++) begin
      exp8 = '1;
      for (int r = FR8; r < N8; r++)
        if (c >= KW8) exp8[(N8-1-r)*BW +: BW] = '0;
      check("n8_en", VW'(oen8), VW'(1));
      check("n8_data", VW'(dout8), VW'(exp8));
      check("n8_last", VW'(olast8), VW'(c == N8 - 1));
      tick();
    end
    check("n8_idle", VW'(oen8), '0);

    drain();
    check("sb_drained", VW'(sb.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
